// File: rtl/softmax_pkg.sv
// Shared softmax pipeline definitions: widths, FSM state, saturating subtract.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package softmax_pkg;

    localparam int DATA_WIDTH_IN_DEF  = 16;
    localparam int DATA_WIDTH_OUT_DEF = 17;

    // Internal arithmetic width for the subtract: two bits of headroom over
    // the widest operand the helpers accept (64 bits).
    localparam int WIDE_W = 66;
    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Sign- or zero-extend the low w_in bits of v.
    function automatic wide_t ext_val(input logic [63:0] v, input int w_in, input bit signed_in);
        wide_t one;
        wide_t span;
        wide_t r;
        one  = wide_t'(1);
        span = one <<< w_in;
        r    = $signed({2'b00, v}) & (span - one);
        if (signed_in && (r >= (span >>> 1))) begin
            r = r - span;
        end
        return r;
    endfunction

    // ext(a) - ext(b), clamped to the signed range of w_out bits. The result
    // sits in the low w_out bits of the returned word.
    function automatic logic [63:0] sat_sub(input logic [63:0] a, input logic [63:0] b,
                                            input int w_in, input int w_out,
                                            input bit signed_in);
        wide_t one;
        wide_t d;
        wide_t lo;
        wide_t hi;
        one = wide_t'(1);
        d   = ext_val(a, w_in, signed_in) - ext_val(b, w_in, signed_in);
        lo  = -(one <<< (w_out - 1));
        hi  = (one <<< (w_out - 1)) - one;
        if (d < lo) begin
            d = lo;
        end else if (d > hi) begin
            d = hi;
        end
        return d[63:0];
    endfunction

endpackage

// File: rtl/softmax_vec_buf.sv
// Vector buffer: one write port, one combinational read port, no reset.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the owner sequences reads and writes.
module softmax_vec_buf
    import softmax_pkg::*;
#(
    parameter int DEPTH = 1000,
    parameter int WIDTH = DATA_WIDTH_IN_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk1,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk1) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/softmax_max_sub_stream.sv
// Buffers one vector while tracking its max, then replays x_i - max (saturated).
// Latency: first output 1 cycle after the closing input transfer, then 1/cycle.
// Backpressure: in_ready low while draining; output held while out_ready is low.
module softmax_max_sub_stream
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = DATA_WIDTH_IN_DEF,
    parameter int DATA_WIDTH_OUT = DATA_WIDTH_OUT_DEF,
    parameter int VEC_MAX        = 1000,
    parameter int SIGNED_IN      = 1,
    parameter int PTR_W          = $clog2(VEC_MAX)
) (
    input  logic                      clk1,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH_IN-1:0]  in_data,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [DATA_WIDTH_OUT-1:0] out_data,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic [PTR_W:0]            vec_len,
    output logic                      err_ovf
);

    // Max register restarts at the smallest representable input value.
    localparam logic [DATA_WIDTH_IN-1:0] MAX_INIT =
        (SIGNED_IN != 0) ? (DATA_WIDTH_IN'(1) << (DATA_WIDTH_IN - 1)) : '0;
    localparam logic [PTR_W-1:0] LAST_WR  = PTR_W'(VEC_MAX - 1);
    localparam logic [PTR_W:0]   VLEN_ONE = (PTR_W + 1)'(1);

    state_t                      state_q;
    state_t                      state_d;
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [DATA_WIDTH_IN-1:0]    max_q;
    logic [DATA_WIDTH_IN-1:0]    buf_rd_dat;
    logic [DATA_WIDTH_OUT-1:0]   sat_dat;
    logic                        in_fire;
    logic                        fill_end;
    logic                        fill_exit;
    logic                        out_fire;
    logic                        drain_done;
    logic                        issue;
    logic                        in_gt_max;

    assign in_fire    = in_valid && in_ready;
    assign fill_end   = (wr_ptr == LAST_WR);
    assign fill_exit  = in_fire && (in_last || fill_end);
    assign out_fire   = out_valid && out_ready;
    assign drain_done = out_fire && out_last;
    // Load the output stage when it is empty or its non-final element leaves.
    assign issue      = (state_q == DRAIN) && (!out_valid || (out_ready && !out_last));

    assign in_gt_max = (SIGNED_IN != 0) ? ($signed(in_data) > $signed(max_q))
                                        : (in_data > max_q);

    assign sat_dat = DATA_WIDTH_OUT'(sat_sub({{(64 - DATA_WIDTH_IN){1'b0}}, buf_rd_dat},
                                             {{(64 - DATA_WIDTH_IN){1'b0}}, max_q},
                                             DATA_WIDTH_IN, DATA_WIDTH_OUT,
                                             SIGNED_IN != 0));

    softmax_vec_buf #(
        .DEPTH (VEC_MAX),
        .WIDTH (DATA_WIDTH_IN),
        .AW    (PTR_W)
    ) u_buf (
        .clk1    (clk1),
        .wr_en   (in_fire),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_addr (rd_ptr),
        .rd_data (buf_rd_dat)
    );

    // FSM state register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fill until the vector closes, drain until its last element leaves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (fill_exit)  state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // FSM outputs: accept input only while filling, so vectors never overlap.
    always_comb begin
        in_ready = (state_q == FILL);
    end

    // Write side: pointer, running max, captured length and sticky overflow.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            max_q   <= MAX_INIT;
            vec_len <= '0;
            err_ovf <= 1'b0;
        end else if (drain_done) begin
            wr_ptr <= '0;
            max_q  <= MAX_INIT;
        end else if (in_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
            if ((wr_ptr == '0) || in_gt_max) begin
                max_q <= in_data;
            end
            if (fill_exit) begin
                vec_len <= {1'b0, wr_ptr} + VLEN_ONE;
            end
            if (fill_end && !in_last) begin
                err_ovf <= 1'b1;
            end
        end
    end

    // Read side: replay buffer through the saturating subtract into the output stage.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (fill_exit) begin
            rd_ptr <= '0;
        end else if (drain_done) begin
            rd_ptr    <= '0;
            out_valid <= 1'b0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_data  <= sat_dat;
            out_last  <= ({1'b0, rd_ptr} == (vec_len - VLEN_ONE));
            rd_ptr    <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_softmax_max_sub_stream.sv
// Bench for softmax_max_sub_stream: three configurations checked against a list-level model.
// Latency: n/a.
// Backpressure: out_ready driven steady, toggling or random.
module tb_softmax_max_sub_stream;

    localparam int N = 3;

    logic clk1 = 1'b0;
    logic rst_n;
    always #5 clk1 = ~clk1;

    logic [N-1:0]        in_valid;
    logic [N-1:0]        in_last;
    logic [N-1:0]        out_ready;
    logic [N-1:0][15:0]  in_data;
    wire  [N-1:0]        in_ready;
    wire  [N-1:0]        out_valid;
    wire  [N-1:0]        out_last;
    wire  [N-1:0]        err_ovf;
    wire  [16:0]         od0;
    wire  [7:0]          od1;
    wire  [16:0]         od2;
    wire  [10:0]         vl0;
    wire  [4:0]          vl1;
    wire  [2:0]          vl2;
    wire  [N-1:0][16:0]  out_dat;
    wire  [N-1:0][10:0]  vl;

    assign out_dat = {od2, {{9{od1[7]}}, od1}, od0};
    assign vl      = {{8'b0, vl2}, {6'b0, vl1}, vl0};

    // Instance 0: signed, full-width output, deep buffer.
    softmax_max_sub_stream #(.DATA_WIDTH_IN(16), .DATA_WIDTH_OUT(17), .VEC_MAX(1000), .SIGNED_IN(1)) dut_s (
        .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid[0]), .in_data(in_data[0]), .in_last(in_last[0]),
        .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_data(od0), .out_last(out_last[0]),
        .out_ready(out_ready[0]), .vec_len(vl0), .err_ovf(err_ovf[0]));

    // Instance 1: unsigned input, saturating 8-bit output.
    softmax_max_sub_stream #(.DATA_WIDTH_IN(16), .DATA_WIDTH_OUT(8), .VEC_MAX(16), .SIGNED_IN(0)) dut_u (
        .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid[1]), .in_data(in_data[1]), .in_last(in_last[1]),
        .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_data(od1), .out_last(out_last[1]),
        .out_ready(out_ready[1]), .vec_len(vl1), .err_ovf(err_ovf[1]));

    // Instance 2: signed, tiny buffer for overflow behaviour.
    softmax_max_sub_stream #(.DATA_WIDTH_IN(16), .DATA_WIDTH_OUT(17), .VEC_MAX(4), .SIGNED_IN(1)) dut_o (
        .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid[2]), .in_data(in_data[2]), .in_last(in_last[2]),
        .in_ready(in_ready[2]), .out_valid(out_valid[2]), .out_data(od2), .out_last(out_last[2]),
        .out_ready(out_ready[2]), .vec_len(vl2), .err_ovf(err_ovf[2]));

    typedef struct {
        logic [15:0] d;
        bit          last;
        bit          ends;
    } in_item_t;

    typedef struct {
        logic [16:0] d;
        bit          last;
    } out_item_t;

    in_item_t  in_q[$];
    out_item_t exp_q[$];
    int        len_q[$];
    bit        ovf_q[$];
    bit        ovf_m [N];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int vmax(input int k);
        return (k == 0) ? 1000 : (k == 1) ? 16 : 4;
    endfunction

    function automatic int wout(input int k);
        return (k == 1) ? 8 : 17;
    endfunction

    function automatic int interp(input int k, input logic [15:0] v);
        int r;
        if (k == 1) r = {16'b0, v};
        else        r = $signed(v);
        return r;
    endfunction

    task automatic push_in(input int v, input bit last);
        in_item_t it;
        it.d    = v[15:0];
        it.last = last;
        it.ends = 1'b0;
        in_q.push_back(it);
    endtask

    // Reference: split the stream into vectors, subtract each vector's max, clamp.
    task automatic model(input int k);
        int        cur[$];
        int        mx;
        int        d;
        int        lo;
        logic [31:0] dv;
        out_item_t o;
        lo = -(1 << (wout(k) - 1));
        foreach (in_q[i]) begin
            cur.push_back(interp(k, in_q[i].d));
            if (in_q[i].last || cur.size() == vmax(k)) begin
                in_q[i].ends = 1'b1;
                if (!in_q[i].last) ovf_m[k] = 1'b1;
                mx = cur[0];
                foreach (cur[j]) if (cur[j] > mx) mx = cur[j];
                foreach (cur[j]) begin
                    d = cur[j] - mx;
                    if (d < lo) d = lo;
                    dv     = d;
                    o.d    = dv[16:0];
                    o.last = (j == cur.size() - 1);
                    exp_q.push_back(o);
                end
                len_q.push_back(cur.size());
                ovf_q.push_back(ovf_m[k]);
                cur.delete();
            end
        end
    endtask

    // Drive the queued stream into instance k and check every output slot.
    // mode: 0 = out_ready high, 1 = toggle each cycle, 2 = random.
    task automatic run(input int k, input int mode, input bit gaps);
        int          cyc;
        int          lat;
        bit          after_last;
        bit          expect_vld;
        bit          held;
        bit          tog;
        bit          rdy;
        bit          vld;
        logic [17:0] held_v;
        out_item_t   e;
        cyc = 0; lat = 0; after_last = 0; expect_vld = 0; held = 0; tog = 0; held_v = '0;
        model(k);
        while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < 3000) begin
            if (lat == 1) begin
                check("lat1_out_valid", out_valid[k], 0);
                check("err_ovf", err_ovf[k], ovf_q.pop_front());
                lat = 2;
            end else if (lat == 2) begin
                check("lat2_out_valid", out_valid[k], 1);
                check("vec_len", vl[k], len_q.pop_front());
                lat = 0;
            end
            if (after_last) begin
                check("post_last_in_ready", in_ready[k], 1);
                check("post_last_out_valid", out_valid[k], 0);
                after_last = 0;
            end
            if (expect_vld) begin
                check("no_bubble", out_valid[k], 1);
                expect_vld = 0;
            end
            if (held) begin
                check("hold", {out_valid[k], out_last[k], out_dat[k]}, {1'b1, held_v});
                held = 0;
            end
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? !tog : 1'($urandom_range(0, 1));
            tog = !tog;
            out_ready[k] = rdy;
            if (out_valid[k]) begin
                check("drain_in_ready", in_ready[k], 0);
                if (rdy) begin
                    if (exp_q.size() == 0) begin
                        check("extra_output", out_valid[k], 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_dat[k], e.d);
                        check("out_last", out_last[k], e.last);
                        if (e.last) after_last = 1;
                        else        expect_vld = 1;
                    end
                end else begin
                    held   = 1;
                    held_v = {out_last[k], out_dat[k]};
                end
            end
            if (in_q.size() > 0) begin
                vld = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_valid[k] = vld;
                in_data[k]  = in_q[0].d;
                in_last[k]  = in_q[0].last;
                if (vld && in_ready[k]) begin
                    if (in_q[0].ends) lat = 1;
                    void'(in_q.pop_front());
                end
            end else begin
                in_valid[k] = 1'b0;
                in_last[k]  = 1'b0;
            end
            @(posedge clk1); #1;
            cyc++;
        end
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
        if (cyc >= 3000) check("timeout_cycles", cyc, 0);
        if (after_last) begin
            check("post_last_in_ready", in_ready[k], 1);
            check("post_last_out_valid", out_valid[k], 0);
        end
        @(posedge clk1); #1;
        check("idle_out_valid", out_valid[k], 0);
        in_q.delete();
        exp_q.delete();
        len_q.delete();
        ovf_q.delete();
    endtask

    initial begin
        int nvec;
        int len;
        int v;
        in_valid  = '0;
        in_last   = '0;
        out_ready = '0;
        in_data   = '0;
        for (int k = 0; k < N; k++) ovf_m[k] = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk1);
        #1;
        for (int k = 0; k < N; k++) begin
            check("rst_in_ready", in_ready[k], 1);
            check("rst_out_valid", out_valid[k], 0);
            check("rst_out_data", out_dat[k], 0);
            check("rst_out_last", out_last[k], 0);
            check("rst_vec_len", vl[k], 0);
            check("rst_err_ovf", err_ovf[k], 0);
        end
        rst_n = 1'b1;
        @(posedge clk1); #1;

        // Signed mixed vector.
        push_in(3, 0); push_in(-2, 0); push_in(7, 0); push_in(0, 1);
        run(0, 0, 0);
        // Single element.
        push_in(-5, 1);
        run(0, 0, 0);
        // Stalled drain with toggling ready.
        push_in(10, 0); push_in(20, 0); push_in(30, 1);
        run(0, 1, 0);
        // Unsigned input with saturation to 8 bits.
        push_in(0, 0); push_in(65535, 1);
        run(1, 0, 0);
        // Overflow at VEC_MAX=4; the fifth element opens the next vector.
        push_in(1, 0); push_in(2, 0); push_in(3, 0); push_in(4, 0); push_in(5, 1);
        run(2, 0, 0);
        // Equal elements.
        push_in(-100, 0); push_in(-100, 0); push_in(-100, 1);
        run(0, 2, 1);

        // Randomised streams on every configuration.
        for (int k = 0; k < N; k++) begin
            for (int r = 0; r < 6; r++) begin
                nvec = $urandom_range(1, 3);
                for (int n = 0; n < nvec; n++) begin
                    len = $urandom_range(1, (k == 2) ? 7 : 10);
                    for (int i = 0; i < len; i++) begin
                        v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 65535));
                        push_in(v, i == len - 1);
                    end
                end
                run(k, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end
        end

        // Reset in the middle of a stalled drain.
        out_ready[0] = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 16'(i);
            in_last[0]  = (i == 3);
            @(posedge clk1); #1;
        end
        in_valid[0] = 1'b0;
        in_last[0]  = 1'b0;
        repeat (3) @(posedge clk1);
        #1;
        check("pre_rst_out_valid", out_valid[0], 1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_out_valid", out_valid[0], 0);
        check("mid_rst_in_ready", in_ready[0], 1);
        check("mid_rst_vec_len", vl[0], 0);
        check("mid_rst_ovf_clear", err_ovf[2], 0);
        @(posedge clk1); #1;
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) ovf_m[k] = 1'b0;
        @(posedge clk1); #1;
        check("post_rst_out_valid", out_valid[0], 0);
        push_in(4, 0); push_in(4, 1);
        run(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/softmax_max_sub_stream.md
Name: softmax_max_sub_stream

Overview:
- Front-end stage of the next-generation softmax pipeline. Buffers one input vector of up to VEC_MAX elements while tracking its maximum, then replays the vector as x_i - max.
- Every output element is therefore <= 0, ready for the exp LUT stage.
- Generalises the fixed-size input path:
  - runtime vector length via in_last;
  - signed or unsigned input mode;
  - configurable output width with saturation;
  - valid/ready backpressure on both sides.

Parameters:
- DATA_WIDTH_IN, 16: input element width.
- DATA_WIDTH_OUT, 17: signed output width. Outputs are saturated to this width when it is less than DATA_WIDTH_IN+1.
- VEC_MAX, 1000: maximum elements per vector, which is also the buffer depth.
- SIGNED_IN, 1: 1 = inputs are two's complement; 0 = inputs are unsigned.
- PTR_W, $clog2(VEC_MAX): pointer/count width.

Ports:
- clk1, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: input element valid.
- in_data, in, DATA_WIDTH_IN: input element.
- in_last, in, 1: marks the final element of a vector.
- in_ready, out, 1: block can accept an input element.
- out_valid, out, 1: output element valid.
- out_data, out, DATA_WIDTH_OUT: signed value x_i - max, saturated.
- out_last, out, 1: marks the final output element of a vector.
- out_ready, in, 1: downstream accepts the output element.
- vec_len, out, PTR_W+1: length of the vector currently draining.
- err_ovf, out, 1: sticky flag; set when a vector reaches VEC_MAX elements without in_last.

Behaviour:
- Handshakes: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready. out_data and out_last are held stable while out_valid && !out_ready.
- Reset: state = FILL; wr_ptr = 0; rd_ptr = 0; max register = most-negative value (SIGNED_IN=1) or 0 (SIGNED_IN=0). Outputs reset to:
  - in_ready = 1;
  - out_valid = 0, out_data = 0, out_last = 0;
  - vec_len = 0, err_ovf = 0.
  - Buffer contents are not reset.
- Reset mid-operation aborts the vector. No partial output is produced after rst_n deasserts.
- FILL state (in_ready = 1):
  - On each input transfer: buf[wr_ptr] <= in_data; wr_ptr++.
  - max <= in_data if in_data > max, compared under SIGNED_IN semantics. The first element of a vector always loads max.
  - Exit condition: the transfer has in_last=1, or wr_ptr == VEC_MAX-1. In the second case without in_last, set err_ovf and treat the element as last.
  - On exit: vec_len <= wr_ptr+1; go to DRAIN; rd_ptr <= 0.
- DRAIN state (in_ready = 0):
  - Output registers load when out_valid==0 || out_ready.
  - out_data <= sat(ext(buf[rd_ptr]) - ext(max)). ext is a sign- or zero-extension to DATA_WIDTH_IN+1, chosen by SIGNED_IN.
  - sat clamps to -2^(DATA_WIDTH_OUT-1) when the output width is narrower.
  - out_last <= (rd_ptr == vec_len-1); rd_ptr++.
- Latency: out_valid rises 1 cycle after the in_last transfer. With out_ready held high, the block emits 1 element per cycle.
- Return to FILL: when the element with out_last=1 transfers, return to FILL. In the same cycle clear wr_ptr and rd_ptr and reset max. in_ready is 1 on the next cycle; there is no overlap between vectors.
- Bubble removal: out_valid drops after the last transfer unless the block reloads. No bubbles are permitted inside a vector when out_ready=1.
- Degenerate vectors:
  - A single-element vector produces exactly one output of 0 with out_last=1.
  - Equal elements all produce 0.
- err_ovf clears only on reset.

Decomposition:
- Shared package softmax_pkg holds:
  - the DATA_WIDTH_IN/DATA_WIDTH_OUT defaults;
  - a state enum {FILL, DRAIN};
  - a sat_sub function (extend, subtract, clamp), reused later by the LUT stage.
- One sub-module, softmax_vec_buf: a single-write, single-read register-array buffer of VEC_MAX x DATA_WIDTH_IN with combinational read. This keeps the buffer swappable for an SRAM macro later.
- The FSM, max tracker and output register remain in the top module.

Test Plan:
- Signed vector {3, -2, 7, 0} with in_last on 0 and out_ready=1 → outputs {-4, -9, 0, -7}; out_last only on -7; vec_len=4; first out_valid 1 cycle after the in_last transfer.
- Single element {-5} → one output of 0 with out_last=1. in_ready returns to 1 the cycle after that transfer.
- out_ready toggled 1/0 every other cycle during drain of {10, 20, 30} → {-20, -10, 0}. Each value is held unchanged while stalled; no loss and no duplication.
- SIGNED_IN=0, DATA_WIDTH_OUT=8, vector {0, 65535} → outputs {-128 (saturated), 0}.
- VEC_MAX=4, send 5 elements {1, 2, 3, 4, 5} with no in_last:
  - err_ovf=1 after the 4th element;
  - outputs {-3, -2, -1, 0} with out_last on 0;
  - in_ready=0 throughout drain, so element 5 is taken as the first element of the next vector.
- Assert rst_n low mid-drain of {1, 2, 3} → out_valid=0 and in_ready=1 after reset. Then {4, 4} → {0, 0}; no stale data appears.
